// File: rtl/ctrl_pkg.sv
// Shared control-pipeline types, forwarding selects and opcode constants.
// Imported by the hazard unit and the control pipeline top.
package ctrl_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef struct packed {
        logic [1:0] aluOp;
        logic       aluSrc;
        logic       branch;
    } ex_ctrl_t;

    typedef struct packed {
        logic memRead;
        logic memWrite;
    } mem_ctrl_t;

    typedef struct packed {
        logic memToReg;
        logic regWrite;
    } wb_ctrl_t;

    // The nearer stage (MEM) holds the younger result, so it wins.
    function automatic logic [1:0] fwdSel(
        input logic       memRw,
        input logic [4:0] memRd,
        input logic       wbRw,
        input logic [4:0] wbRd,
        input logic [4:0] rs
    );
        if (memRw && memRd != 5'd0 && memRd == rs)
            return FWD_MEM;
        else if (wbRw && wbRd != 5'd0 && wbRd == rs)
            return FWD_WB;
        else
            return FWD_NONE;
    endfunction

endpackage

// File: rtl/ctrl_pipe_hazard.sv
// Combinational load-use stall, taken-branch flush and operand forwarding.
// Flush wins over stall since the stalled ID instruction is being killed.
module hazard_unit
    import ctrl_pkg::*;
(
    input  logic       exMemRead,
    input  logic       exBranch,
    input  logic       exZero,
    input  logic [4:0] exRd,
    input  logic [4:0] exRs1,
    input  logic [4:0] exRs2,
    input  logic [4:0] idRs1,
    input  logic [4:0] idRs2,
    input  logic       memRegWrite,
    input  logic [4:0] memRd,
    input  logic       wbRegWrite,
    input  logic [4:0] wbRd,
    output logic       stall,
    output logic       flush,
    output logic [1:0] fwdA,
    output logic [1:0] fwdB
);

    logic loadUse;

    always_comb begin
        loadUse = exMemRead && exRd != 5'd0
                  && (exRd == idRs1 || exRd == idRs2);
        flush   = exBranch && exZero;
        stall   = loadUse && !flush;
        fwdA    = fwdSel(memRegWrite, memRd, wbRegWrite, wbRd, exRs1);
        fwdB    = fwdSel(memRegWrite, memRd, wbRegWrite, wbRd, exRs2);
    end

endmodule

// File: rtl/ctrl_pipe.sv
// ID->EX->MEM->WB control pipeline registers with hazard handling.
// Each control bit only travels as far as the stage that consumes it.
module ctrl_pipe
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_branch,
    input  logic       id_mem_read,
    input  logic       id_mem_to_reg,
    input  logic       id_mem_write,
    input  logic       id_alu_src,
    input  logic       id_reg_write,
    input  logic [1:0] id_alu_op,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] id_rd,
    input  logic       ex_zero,
    output logic [1:0] ex_alu_op,
    output logic       ex_alu_src,
    output logic       ex_branch,
    output logic [4:0] ex_rs1,
    output logic [4:0] ex_rs2,
    output logic [4:0] ex_rd,
    output logic       mem_mem_read,
    output logic       mem_mem_write,
    output logic       mem_reg_write,
    output logic [4:0] mem_rd,
    output logic       wb_mem_to_reg,
    output logic       wb_reg_write,
    output logic [4:0] wb_rd,
    output logic       stall,
    output logic       flush,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    ex_ctrl_t  exEx;
    mem_ctrl_t exMem;
    wb_ctrl_t  exWb;
    logic [4:0] exRs1, exRs2, exRd;

    mem_ctrl_t memMem;
    wb_ctrl_t  memWb;
    logic [4:0] memRd;

    wb_ctrl_t  wbWb;
    logic [4:0] wbRd;

    logic bubble;

    hazard_unit uHazard (
        .exMemRead   (exMem.memRead),
        .exBranch    (exEx.branch),
        .exZero      (ex_zero),
        .exRd        (exRd),
        .exRs1       (exRs1),
        .exRs2       (exRs2),
        .idRs1       (id_rs1),
        .idRs2       (id_rs2),
        .memRegWrite (memWb.regWrite),
        .memRd       (memRd),
        .wbRegWrite  (wbWb.regWrite),
        .wbRd        (wbRd),
        .stall       (stall),
        .flush       (flush),
        .fwdA        (fwd_a),
        .fwdB        (fwd_b)
    );

    assign bubble = stall | flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exEx   <= '0;
            exMem  <= '0;
            exWb   <= '0;
            exRs1  <= '0;
            exRs2  <= '0;
            exRd   <= '0;
            memMem <= '0;
            memWb  <= '0;
            memRd  <= '0;
            wbWb   <= '0;
            wbRd   <= '0;
        end else begin
            if (bubble) begin
                exEx  <= '0;
                exMem <= '0;
                exWb  <= '0;
                exRs1 <= '0;
                exRs2 <= '0;
                exRd  <= '0;
            end else begin
                exEx  <= '{aluOp: id_alu_op,
                           aluSrc: id_alu_src,
                           branch: id_branch};
                exMem <= '{memRead: id_mem_read,
                           memWrite: id_mem_write};
                exWb  <= '{memToReg: id_mem_to_reg,
                           regWrite: id_reg_write};
                exRs1 <= id_rs1;
                exRs2 <= id_rs2;
                exRd  <= id_rd;
            end
            memMem <= exMem;
            memWb  <= exWb;
            memRd  <= exRd;
            wbWb   <= memWb;
            wbRd   <= memRd;
        end
    end

    assign ex_alu_op     = exEx.aluOp;
    assign ex_alu_src    = exEx.aluSrc;
    assign ex_branch     = exEx.branch;
    assign ex_rs1        = exRs1;
    assign ex_rs2        = exRs2;
    assign ex_rd         = exRd;
    assign mem_mem_read  = memMem.memRead;
    assign mem_mem_write = memMem.memWrite;
    assign mem_reg_write = memWb.regWrite;
    assign mem_rd        = memRd;
    assign wb_mem_to_reg = wbWb.memToReg;
    assign wb_reg_write  = wbWb.regWrite;
    assign wb_rd         = wbRd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Table-driven bench for ctrl_pipe with a three-deep stage scoreboard.
// Hazard expectations are hand-derived per step; stage contents are modelled.
module tb_ctrl_pipe;

    logic       clk, rst_n;
    logic       id_branch, id_mem_read, id_mem_to_reg, id_mem_write;
    logic       id_alu_src, id_reg_write;
    logic [1:0] id_alu_op;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_zero;
    logic [1:0] ex_alu_op;
    logic       ex_alu_src, ex_branch;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       mem_mem_read, mem_mem_write, mem_reg_write;
    logic [4:0] mem_rd;
    logic       wb_mem_to_reg, wb_reg_write;
    logic [4:0] wb_rd;
    logic       stall, flush;
    logic [1:0] fwd_a, fwd_b;

    ctrl_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .id_branch(id_branch), .id_mem_read(id_mem_read),
        .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_alu_op(id_alu_op), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .ex_zero(ex_zero),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_branch(ex_branch), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_reg_write(mem_reg_write),
        .mem_rd(mem_rd), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       br, mr, m2r, mw, as, rw;
        logic [1:0] op;
        logic [4:0] rs1, rs2, rd;
        logic       z, st, fl;
        logic [1:0] fa, fb;
    } vec_t;

    typedef struct packed {
        logic [1:0] op;
        logic       as, br, mr, mw, m2r, rw;
        logic [4:0] rs1, rs2, rd;
    } stg_t;

    localparam int K_NOP = 0, K_R = 1, K_LD = 2;
    localparam int K_SD = 3, K_BEQ = 4, K_ODD = 5;
    localparam int NV = 30;

    int checks = 0;
    int failures = 0;
    int step = 0;
    vec_t v[NV];
    stg_t q[$];

    function automatic vec_t mk(
        input int k, input logic [4:0] rs1, rs2, rd,
        input logic z, st, fl, input logic [1:0] fa, fb
    );
        vec_t r;
        r.br = 0; r.mr = 0; r.m2r = 0; r.mw = 0;
        r.as = 0; r.rw = 0; r.op = 2'b00;
        case (k)
            K_R:   begin r.op = 2'b10; r.rw = 1; end
            K_LD:  begin r.mr = 1; r.m2r = 1; r.as = 1; r.rw = 1; end
            K_SD:  begin r.mw = 1; r.as = 1; r.m2r = 1; end
            K_BEQ: begin r.br = 1; r.op = 2'b01; end
            K_ODD: begin r.br = 1; r.mr = 1; r.rw = 1; r.op = 2'b01; end
            default: ;
        endcase
        r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
        r.z = z; r.st = st; r.fl = fl; r.fa = fa; r.fb = fb;
        return r;
    endfunction

    task automatic chk(input string name,
                       input logic [63:0] act, exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%h want=%h",
                     name, step, act, exp);
        end
    endtask

    task automatic drive(input vec_t d);
        id_branch = d.br; id_mem_read = d.mr;
        id_mem_to_reg = d.m2r; id_mem_write = d.mw;
        id_alu_src = d.as; id_reg_write = d.rw;
        id_alu_op = d.op; id_rs1 = d.rs1;
        id_rs2 = d.rs2; id_rd = d.rd; ex_zero = d.z;
    endtask

    function automatic logic [39:0] allOut();
        return {ex_alu_op, ex_alu_src, ex_branch, ex_rs1, ex_rs2,
                ex_rd, mem_mem_read, mem_mem_write, mem_reg_write,
                mem_rd, wb_mem_to_reg, wb_reg_write, wb_rd,
                stall, flush, fwd_a, fwd_b};
    endfunction

    initial begin
        stg_t e, m, w, n;
        v[0]  = mk(K_R,   1, 2, 5,  0, 0, 0, 2'b00, 2'b00);
        v[1]  = mk(K_NOP, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
        v[2]  = mk(K_NOP, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
        v[3]  = mk(K_LD,  4, 0, 3,  0, 0, 0, 2'b00, 2'b00);
        v[4]  = mk(K_R,   3, 1, 6,  0, 1, 0, 2'b00, 2'b00);
        v[5]  = mk(K_R,   3, 1, 6,  0, 0, 0, 2'b00, 2'b00);
        v[6]  = mk(K_NOP, 0, 0, 0,  0, 0, 0, 2'b01, 2'b00);
        v[7]  = mk(K_R,   1, 2, 7,  0, 0, 0, 2'b00, 2'b00);
        v[8]  = mk(K_R,   2, 3, 7,  0, 0, 0, 2'b00, 2'b00);
        v[9]  = mk(K_R,   7, 7, 8,  0, 0, 0, 2'b00, 2'b00);
        v[10] = mk(K_NOP, 0, 0, 0,  0, 0, 0, 2'b10, 2'b10);
        v[11] = mk(K_R,   1, 2, 0,  0, 0, 0, 2'b00, 2'b00);
        v[12] = mk(K_R,   1, 2, 0,  0, 0, 0, 2'b00, 2'b00);
        v[13] = mk(K_R,   0, 0, 10, 0, 0, 0, 2'b00, 2'b00);
        v[14] = mk(K_NOP, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
        v[15] = mk(K_LD,  1, 0, 0,  0, 0, 0, 2'b00, 2'b00);
        v[16] = mk(K_R,   0, 0, 11, 0, 0, 0, 2'b00, 2'b00);
        v[17] = mk(K_BEQ, 1, 2, 0,  0, 0, 0, 2'b00, 2'b00);
        v[18] = mk(K_R,   4, 5, 12, 1, 0, 1, 2'b00, 2'b00);
        v[19] = mk(K_NOP, 0, 0, 0,  1, 0, 0, 2'b00, 2'b00);
        v[20] = mk(K_BEQ, 1, 2, 0,  0, 0, 0, 2'b00, 2'b00);
        v[21] = mk(K_R,   4, 5, 13, 0, 0, 0, 2'b00, 2'b00);
        v[22] = mk(K_NOP, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
        v[23] = mk(K_ODD, 1, 2, 9,  0, 0, 0, 2'b00, 2'b00);
        v[24] = mk(K_R,   9, 1, 14, 1, 0, 1, 2'b00, 2'b00);
        v[25] = mk(K_SD,  1, 9, 0,  0, 0, 0, 2'b00, 2'b00);
        v[26] = mk(K_NOP, 0, 0, 0,  0, 0, 0, 2'b00, 2'b01);
        v[27] = mk(K_NOP, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
        v[28] = mk(K_NOP, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
        v[29] = mk(K_NOP, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);

        rst_n = 1'b0;
        drive(mk(K_R, 3, 3, 3, 1, 0, 0, 2'b00, 2'b00));
        #1;
        chk("reset_outputs", {24'd0, allOut()}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        drive(v[1]);
        rst_n = 1'b1;
        repeat (3) q.push_back('0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            step = i;
            drive(v[i]);
            #1;
            e = q[2]; m = q[1]; w = q[0];
            chk("stall", {63'd0, stall}, {63'd0, v[i].st});
            chk("flush", {63'd0, flush}, {63'd0, v[i].fl});
            chk("fwd_a", {62'd0, fwd_a}, {62'd0, v[i].fa});
            chk("fwd_b", {62'd0, fwd_b}, {62'd0, v[i].fb});
            chk("ex_stage",
                {45'd0, ex_alu_op, ex_alu_src, ex_branch,
                 ex_rs1, ex_rs2, ex_rd},
                {45'd0, e.op, e.as, e.br, e.rs1, e.rs2, e.rd});
            chk("mem_stage",
                {56'd0, mem_mem_read, mem_mem_write,
                 mem_reg_write, mem_rd},
                {56'd0, m.mr, m.mw, m.rw, m.rd});
            chk("wb_stage",
                {57'd0, wb_mem_to_reg, wb_reg_write, wb_rd},
                {57'd0, w.m2r, w.rw, w.rd});
            n = '0;
            if (!(v[i].st || v[i].fl)) begin
                n.op = v[i].op; n.as = v[i].as; n.br = v[i].br;
                n.mr = v[i].mr; n.mw = v[i].mw; n.m2r = v[i].m2r;
                n.rw = v[i].rw; n.rs1 = v[i].rs1;
                n.rs2 = v[i].rs2; n.rd = v[i].rd;
            end
            q.push_back(n);
            void'(q.pop_front());
        end

        step = 100;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            drive(mk(K_R, 5'(k), 5'(k), 5'(k), 0, 0, 0, 2'b00, 2'b00));
        end
        @(negedge clk);
        drive(mk(K_R, 1, 2, 3, 0, 0, 0, 2'b00, 2'b00));
        #1;
        chk("inflight_wb_rd", {59'd0, wb_rd}, 64'd1);
        chk("inflight_mem_rw", {63'd0, mem_reg_write}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {24'd0, allOut()}, 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        drive(mk(K_R, 4, 4, 4, 0, 0, 0, 2'b00, 2'b00));
        @(negedge clk);
        drive(v[1]);
        #1;
        step = 101;
        chk("post_ex", {52'd0, ex_alu_op, ex_rd, ex_rs1},
            {52'd0, 2'b10, 5'd4, 5'd4});
        chk("post_mem_rw", {63'd0, mem_reg_write}, 64'd0);
        chk("post_wb_rw", {63'd0, wb_reg_write}, 64'd0);
        @(negedge clk);
        #1;
        step = 102;
        chk("post_mem", {58'd0, mem_reg_write, mem_rd}, {58'd0, 1'b1, 5'd4});
        chk("post_wb_rw2", {63'd0, wb_reg_write}, 64'd0);
        @(negedge clk);
        #1;
        step = 103;
        chk("post_wb", {57'd0, wb_reg_write, wb_mem_to_reg, wb_rd},
            {57'd0, 1'b1, 1'b0, 5'd4});
        chk("post_mem_rw3", {63'd0, mem_reg_write}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
